// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU control codes and execute-stage FSM encoding
package alu_ctrl_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_ADDI = 3'b110;
  localparam logic [2:0] ALU_SRAI = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/multicycle_alu_if.sv
// rtl/multicycle_alu_if.sv - request/response bundle between issue logic and the ALU
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             busy_o;

  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i,
    output ready_o, valid_o, data_o, zero_o, busy_o
  );

  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i,
    input  ready_o, valid_o, data_o, zero_o, busy_o
  );
endinterface

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             run_q, run_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_next;

  // product includes the last partial sum so the top can register it on the final step edge
  always_comb begin
    acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    done     = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    product  = acc_next;
    run_d    = run_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start) begin
      run_d    = 1'b1;
      mcand_d  = d1;
      mplier_d = d2;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (run_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      run_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      run_q    <= run_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - execute-stage ALU with single-cycle ops and an iterative multiply
module multicycle_alu
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  multicycle_alu_if.slave  bus
);
  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic             ready;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_res;
  logic [SHAMT_W-1:0] shamt;

  // ready/busy are forced low while reset is held so the hazard unit sees no stall
  assign ready       = rst_i && (state_q == ST_IDLE);
  assign accept      = bus.valid_i && ready;
  assign bus.ready_o = ready;
  assign bus.busy_o  = rst_i && (state_q == ST_MUL);
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.zero_o  = zero_q;
  assign shamt       = bus.data2_i[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.ALUCtrl_i)
      ALU_AND:  alu_res = bus.data1_i & bus.data2_i;
      ALU_XOR:  alu_res = bus.data1_i ^ bus.data2_i;
      ALU_SLL:  alu_res = bus.data1_i << shamt;
      ALU_ADD:  alu_res = bus.data1_i + bus.data2_i;
      ALU_SUB:  alu_res = bus.data1_i - bus.data2_i;
      ALU_ADDI: alu_res = bus.data1_i + bus.data2_i;
      ALU_SRAI: alu_res = WIDTH'($signed(bus.data1_i) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    zero_d    = zero_q;
    valid_d   = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.ALUCtrl_i == ALU_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            data_d  = alu_res;
            zero_d  = (alu_res == '0);
            valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          data_d  = mul_product;
          zero_d  = (mul_product == '0);
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (mul_start),
    .d1      (bus.data1_i),
    .d2      (bus.data2_i),
    .done    (mul_done),
    .product (mul_product)
  );
endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - directed and randomized self-checking bench for multicycle_alu
module tb_multicycle_alu;
  import alu_ctrl_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(W)) bus();
  multicycle_alu #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [4:0]   sh;
    logic [W-1:0] r;
    sh = b[4:0];
    case (op)
      ALU_AND:  r = a & b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << sh;
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_MUL:  r = a * b;
      ALU_ADDI: r = a + b;
      default: begin
        r = a >> sh;
        if (a[W-1]) r = r | ~({W{1'b1}} >> sh);
      end
    endcase
    return r;
  endfunction

  // transaction-level model: a multiply occupies the block for W edges, everything else one
  int           mul_left  = 0;
  logic [W-1:0] mul_res   = '0;
  logic [W-1:0] exp_data  = '0;
  logic         exp_valid = 1'b0;
  logic         exp_zero  = 1'b0;
  logic         live      = 1'b0;

  always @(posedge clk) begin
    live <= 1'b1;
    if (!rst_n) begin
      mul_left  <= 0;
      exp_valid <= 1'b0;
      exp_data  <= '0;
      exp_zero  <= 1'b0;
    end else if (mul_left > 0) begin
      mul_left  <= mul_left - 1;
      exp_valid <= (mul_left == 1);
      if (mul_left == 1) begin
        exp_data <= mul_res;
        exp_zero <= (mul_res == '0);
      end
    end else if (bus.valid_i) begin
      if (bus.ALUCtrl_i == ALU_MUL) begin
        mul_left  <= W;
        mul_res   <= ref_op(ALU_MUL, bus.data1_i, bus.data2_i);
        exp_valid <= 1'b0;
      end else begin
        exp_data  <= ref_op(bus.ALUCtrl_i, bus.data1_i, bus.data2_i);
        exp_zero  <= (ref_op(bus.ALUCtrl_i, bus.data1_i, bus.data2_i) == '0);
        exp_valid <= 1'b1;
      end
    end else begin
      exp_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("cmp_valid", bus.valid_o, exp_valid);
      chk("cmp_ready", bus.ready_o, rst_n && (mul_left == 0));
      chk("cmp_busy",  bus.busy_o,  rst_n && (mul_left != 0));
      chk("cmp_data",  bus.data_o,  exp_data);
      chk("cmp_zero",  bus.zero_o,  exp_zero);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.valid_i   = v;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {W{1'b1}};
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_valid(output int k);
    k = 0;
    while (!bus.valid_o && k < 40) begin
      chk("mul_ready_low", bus.ready_o, 1'b0);
      if (k == 3) drive(1'b1, ALU_ADD, 32'd1, 32'd1);
      if (k == 6) drive(1'b0, ALU_ADD, '0, '0);
      step();
      k++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int pulses;
    drive(1'b0, ALU_AND, '0, '0);
    step();
    step();
    chk("rst_data", bus.data_o, '0);
    chk("rst_valid", bus.valid_o, 1'b0);
    chk("rst_ready", bus.ready_o, 1'b0);
    chk("rst_busy", bus.busy_o, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("release_ready", bus.ready_o, 1'b1);

    drive(1'b1, ALU_ADD, 32'd5, 32'd7);
    step();
    drive(1'b0, ALU_ADD, '0, '0);
    chk("add_valid", bus.valid_o, 1'b1);
    chk("add_data", bus.data_o, 32'd12);
    chk("add_zero", bus.zero_o, 1'b0);
    step();
    chk("add_valid_drop", bus.valid_o, 1'b0);

    drive(1'b1, ALU_SUB, 32'h5, 32'h5);
    step();
    chk("sub_eq_data", bus.data_o, '0);
    chk("sub_eq_zero", bus.zero_o, 1'b1);
    drive(1'b1, ALU_SUB, 32'h0, 32'h1);
    step();
    chk("sub_wrap", bus.data_o, 32'hFFFF_FFFF);
    drive(1'b1, ALU_SLL, 32'h1, 32'd31);
    step();
    chk("sll31", bus.data_o, 32'h8000_0000);
    drive(1'b1, ALU_SRAI, 32'h8000_0000, 32'd4);
    step();
    chk("srai4", bus.data_o, 32'hF800_0000);
    drive(1'b1, ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step();
    chk("and", bus.data_o, 32'hF000_F000);
    drive(1'b1, ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step();
    chk("xor", bus.data_o, 32'h0FF0_0FF0);

    drive(1'b1, ALU_ADD, 32'd10, 32'd20);
    step();
    chk("b2b_add_valid", bus.valid_o, 1'b1);
    chk("b2b_add", bus.data_o, 32'd30);
    drive(1'b1, ALU_XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    step();
    chk("b2b_xor_valid", bus.valid_o, 1'b1);
    chk("b2b_xor", bus.data_o, 32'hAAAA_AAAA);
    drive(1'b1, ALU_ADDI, 32'hFFFF_FFFF, 32'd2);
    step();
    chk("b2b_addi_valid", bus.valid_o, 1'b1);
    chk("b2b_addi", bus.data_o, 32'd1);
    drive(1'b0, ALU_ADD, '0, '0);
    step();
    chk("b2b_idle", bus.valid_o, 1'b0);

    drive(1'b1, ALU_MUL, 32'hFFFF_FFFF, 32'd3);
    step();
    drive(1'b0, ALU_ADD, '0, '0);
    chk("mul_busy", bus.busy_o, 1'b1);
    wait_valid(k);
    chk("mul_latency", k, 32);
    chk("mul_data", bus.data_o, 32'hFFFF_FFFD);
    chk("mul_done_ready", bus.ready_o, 1'b1);
    drive(1'b1, ALU_MUL, 32'd7, 32'd6);
    step();
    drive(1'b0, ALU_ADD, '0, '0);
    chk("chain_busy", bus.busy_o, 1'b1);
    chk("chain_no_valid", bus.valid_o, 1'b0);
    wait_valid(k);
    chk("chain_latency", k, 32);
    chk("chain_data", bus.data_o, 32'd42);
    step();
    chk("chain_single_pulse", bus.valid_o, 1'b0);

    drive(1'b1, ALU_MUL, 32'd12345, 32'd678);
    step();
    drive(1'b0, ALU_ADD, '0, '0);
    repeat (9) step();
    rst_n = 1'b0;
    step();
    chk("mulrst_data", bus.data_o, '0);
    chk("mulrst_valid", bus.valid_o, 1'b0);
    chk("mulrst_ready", bus.ready_o, 1'b0);
    chk("mulrst_busy", bus.busy_o, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("mulrst_release_ready", bus.ready_o, 1'b1);
    drive(1'b1, ALU_ADD, 32'd2, 32'd2);
    step();
    drive(1'b0, ALU_ADD, '0, '0);
    chk("post_rst_add_valid", bus.valid_o, 1'b1);
    chk("post_rst_add", bus.data_o, 32'd4);
    pulses = 0;
    repeat (40) begin
      step();
      if (bus.valid_o) pulses++;
    end
    chk("abandoned_mul_no_valid", pulses, 0);

    repeat (3000) begin
      rst_n = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), rand_val(), rand_val());
      step();
    end
    rst_n = 1'b1;
    drive(1'b0, ALU_ADD, '0, '0);
    repeat (40) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
